serial_add_ctrl: RTL and testbench

//  Bit-serial adder sequencer. Time-shares one external 1-bit full adder (full_beh: a,b,ci -> s,co)
//  to add two WIDTH-bit operands LSB-first, one bit per clock. Owns operand shift regs, carry

---
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one external combinational full adder LSB-first,
// one bit per clock, and owns operand shifters, carry flop, bit counter and handshake.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:1]   sum_sh;  // bits below the MSB; the MSB comes straight from fa_s
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               accept;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = (state_q == S_IDLE) && start;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_ci   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        fa_a  = a_sh[0];
        fa_b  = b_sh[0];
        fa_ci = carry_q;
        if (last_bit) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sh    <= a_in;
      b_sh    <= b_in;
      sum_sh  <= '0;
      carry_q <= cin;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state_q == S_RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= (WIDTH-1)'({fa_s, sum_sh} >> 1);
      carry_q <= fa_co;
      if (last_bit) begin
        // Counter stops at WIDTH-1 rather than wrapping.
        sum  <= {fa_s, sum_sh};
        cout <= fa_co;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: 8-bit instance for handshake/corner cases,
// 4-bit instance swept over every (a, b, cin) combination.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8, cin8, ready8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       fa8_a, fa8_b, fa8_ci, fa8_s, fa8_co;
  assign {fa8_co, fa8_s} = {1'b0, fa8_a} + {1'b0, fa8_b} + {1'b0, fa8_ci};

  // 4-bit instance
  logic       start4, cin4, ready4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       fa4_a, fa4_b, fa4_ci, fa4_s, fa4_co;
  assign {fa4_co, fa4_s} = {1'b0, fa4_a} + {1'b0, fa4_b} + {1'b0, fa4_ci};

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_a(fa8_a), .fa_b(fa8_b), .fa_ci(fa8_ci), .fa_s(fa8_s), .fa_co(fa8_co)
  );

  serial_add_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .fa_a(fa4_a), .fa_b(fa4_b), .fa_ci(fa4_ci), .fa_s(fa4_s), .fa_co(fa4_co)
  );

  int checks = 0;
  int errors = 0;
  int done4_pulses = 0;

  always @(negedge clk) if (done4 === 1'b1) done4_pulses++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps negedges until done8 is seen (bounded), checking one-hot status each cycle.
  task automatic wait_done8(output int k);
    logic onehot_ok;
    k = 0;
    onehot_ok = 1'b1;
    while (done8 !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
      if (!$onehot({ready8, busy8, done8})) onehot_ok = 1'b0;
    end
    check("onehot8", onehot_ok, 1'b1);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c);
    int k;
    logic [8:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check({tag, "_busy"}, busy8, 1'b1);
    wait_done8(k);
    check({tag, "_latency"}, k, 8);
    check({tag, "_sum"}, sum8, exp[7:0]);
    check({tag, "_cout"}, cout8, exp[8]);
    @(negedge clk);
    check({tag, "_ready_after"}, {ready8, busy8, done8}, 3'b100);
    check({tag, "_held"}, {cout8, sum8}, exp);
  endtask

  // T5 operand table and hand-computed {cout,sum}
  logic [7:0] t5_a   [4] = '{8'h01, 8'h80, 8'h7F, 8'hF0};
  logic [7:0] t5_b   [4] = '{8'h02, 8'h80, 8'h01, 8'h0F};
  logic       t5_c   [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
  logic [8:0] t5_exp [4] = '{9'h003, 9'h100, 9'h081, 9'h100};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    logic no_done;
    logic [4:0] exp4;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #12;
    check("rst_status", {ready8, busy8, done8}, 3'b100);
    check("rst_result", {cout8, sum8}, 9'h000);
    check("rst_fa", {fa8_a, fa8_b, fa8_ci}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // T1 / T2: zero, full ripple, mixed patterns
    op8("t1_zero",   8'h00, 8'h00, 1'b0);
    op8("t2_ripple", 8'hFF, 8'h01, 1'b0);
    op8("t2_a5_5a",  8'hA5, 8'h5A, 1'b1);
    op8("t2_3c_c3",  8'h3C, 8'hC3, 1'b0);
    op8("t2_max",    8'hFF, 8'hFF, 1'b1);

    // T3: start during RUN and during DONE is ignored
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(k);
    check("t3_latency", k, 6);
    check("t3_result", {cout8, sum8}, 9'h046);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("t3_done_start_ignored", {ready8, busy8, done8}, 3'b100);
    @(negedge clk);
    check("t3_no_queue", {ready8, busy8, done8}, 3'b100);
    check("t3_result_held", {cout8, sum8}, 9'h046);

    // T4: reset at cnt=3 mid-RUN
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy_before", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t4_status", {ready8, busy8, done8}, 3'b100);
    check("t4_result", {cout8, sum8}, 9'h000);
    check("t4_fa", {fa8_a, fa8_b, fa8_ci}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    no_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) no_done = 1'b0;
    end
    check("t4_no_done", no_done, 1'b1);

    // T5: start held high across four back-to-back operations
    a8 = t5_a[0]; b8 = t5_b[0]; cin8 = t5_c[0]; start8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        wait_done8(k);
        check("t5_first_latency", k, 9);
      end else begin
        @(negedge clk);
        wait_done8(k);
        check("t5_interval", k + 1, 10);
      end
      check("t5_result", {cout8, sum8}, t5_exp[i]);
      if (i < 3) begin
        a8 = t5_a[i+1]; b8 = t5_b[i+1]; cin8 = t5_c[i+1];
      end else begin
        start8 = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    check("t5_idle_after", {ready8, busy8, done8}, 3'b100);

    // T6: exhaustive 4-bit sweep
    done4_pulses = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
          exp4 = 5'(a + b + c);
          @(negedge clk);
          start4 = 1'b0;
          k = 0;
          while (done4 !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
          end
          check("t6_latency", k, 4);
          check("t6_result", {cout4, sum4}, exp4);
          @(negedge clk);
        end
      end
    end
    check("t6_done_pulses", done4_pulses, 512);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
